// File: rtl/button_event_unit.sv
// Button input conditioning: per-pin sync + debounce, then edge events into a FWFT pop queue.
// Optional long-press events (kind 2'b11) are built when BUTTON_LONGPRESS_EN is defined.

module button_lane #(
  parameter int DEBOUNCE_CYCLES  = 240000,
  parameter int ACTIVE_LOW       = 1,
  parameter int LONGPRESS_CYCLES = 24000000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic state,
  output logic press_set,
  output logic rel_set,
  output logic long_set
);
  localparam int  DBW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic REL = (ACTIVE_LOW != 0);

  logic           sync1, sync2, p, db_hit;
  logic [DBW-1:0] db_cnt;

  assign p         = sync2 ^ REL;
  assign db_hit    = (p != state) && (db_cnt == DBW'(DEBOUNCE_CYCLES - 1));
  assign press_set = db_hit & ~state;
  assign rel_set   = db_hit & state;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1  <= REL;
      sync2  <= REL;
      state  <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      if (p == state) begin
        db_cnt <= '0;
      end else if (db_hit) begin
        state  <= ~state;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

`ifdef BUTTON_LONGPRESS_EN
  localparam int LPW = $clog2(LONGPRESS_CYCLES + 1);
  logic [LPW-1:0] hold_cnt;

  // Counter parks one past the trigger value so a held button fires only once.
  assign long_set = state && (hold_cnt == LPW'(LONGPRESS_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!reset_n || !state) hold_cnt <= '0;
    else if (hold_cnt != LPW'(LONGPRESS_CYCLES)) hold_cnt <= hold_cnt + 1'b1;
  end
`else
  logic unused_lp;
  assign unused_lp = (LONGPRESS_CYCLES > 0);
  assign long_set  = 1'b0;
`endif
endmodule

module button_event_unit #(
  parameter int BUTTONCOUNT      = 4,
  parameter int DEBOUNCE_CYCLES  = 240000,
  parameter int FIFO_DEPTH       = 8,
  parameter int ACTIVE_LOW       = 1,
  parameter int LONGPRESS_CYCLES = 24000000,
  localparam int IDXW = (BUTTONCOUNT > 1) ? $clog2(BUTTONCOUNT) : 1,
  localparam int AW   = $clog2(FIFO_DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [BUTTONCOUNT-1:0] buttons,
  output logic [BUTTONCOUNT-1:0] state,
  output logic                   evt_valid,
  input  logic                   evt_ready,
  output logic [IDXW+1:0]        evt_data,
  output logic [AW:0]            evt_count,
  output logic                   overflow,
  input  logic                   overflow_clr
);
  typedef struct packed {
    logic [1:0]      kind;
    logic [IDXW-1:0] idx;
  } evt_t;

  logic [BUTTONCOUNT-1:0] press_set, rel_set, long_set;
  logic [BUTTONCOUNT-1:0] press_pend, rel_pend, long_pend;
  logic [BUTTONCOUNT-1:0] clr_p, clr_r, clr_l;
  logic                   sel_vld, full, do_push, do_pop;
  evt_t                   sel;
  evt_t [FIFO_DEPTH-1:0]  mem;
  logic [AW-1:0]          wr_ptr, rd_ptr;

  for (genvar i = 0; i < BUTTONCOUNT; i++) begin : g_lane
    button_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .LONGPRESS_CYCLES(LONGPRESS_CYCLES)
    ) u_lane (
      .clk      (clk),
      .reset_n  (reset_n),
      .pin      (buttons[i]),
      .state    (state[i]),
      .press_set(press_set[i]),
      .rel_set  (rel_set[i]),
      .long_set (long_set[i])
    );
  end

  // Lowest index wins; within an index: press, long, release.
  always_comb begin
    sel_vld = 1'b0;
    sel     = '0;
    clr_p   = '0;
    clr_l   = '0;
    clr_r   = '0;
    for (int i = 0; i < BUTTONCOUNT; i++) begin
      if (!sel_vld && (press_pend[i] || long_pend[i] || rel_pend[i])) begin
        sel_vld = 1'b1;
        sel.idx = IDXW'(i);
        if (press_pend[i]) begin
          sel.kind = 2'b01;
          clr_p[i] = 1'b1;
        end else if (long_pend[i]) begin
          sel.kind = 2'b11;
          clr_l[i] = 1'b1;
        end else begin
          sel.kind = 2'b10;
          clr_r[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      press_pend <= '0;
      rel_pend   <= '0;
    end else begin
      press_pend <= (press_pend & ~clr_p) | press_set;
      rel_pend   <= (rel_pend & ~clr_r) | rel_set;
    end
  end

`ifdef BUTTON_LONGPRESS_EN
  always_ff @(posedge clk) begin
    if (!reset_n) long_pend <= '0;
    else          long_pend <= (long_pend & ~clr_l) | long_set;
  end
`else
  logic unused_long;
  assign unused_long = ^{long_set, clr_l};
  assign long_pend   = '0;
`endif

  assign evt_valid = (evt_count != '0);
  assign full      = (evt_count == (AW+1)'(FIFO_DEPTH));
  assign do_pop    = evt_valid && evt_ready;
  // A full queue still accepts a push when the head leaves on the same edge.
  assign do_push   = sel_vld && (!full || do_pop);
  assign evt_data  = evt_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= sel;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      evt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      evt_count <= evt_count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      if (sel_vld && !do_push) overflow <= 1'b1;
      else if (overflow_clr)   overflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_button_event_unit.sv
// Directed bench for button_event_unit with an expected-event queue as scoreboard.
module tb_button_event_unit;
  localparam int BC = 4;
  localparam int DB = 4;
  localparam int FD = 4;
  localparam int LP = 20;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [BC-1:0] buttons;
  logic [BC-1:0] state;
  logic          evt_valid, evt_ready, overflow, overflow_clr;
  logic [3:0]    evt_data;
  logic [2:0]    evt_count;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  button_event_unit #(
    .BUTTONCOUNT(BC), .DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(FD),
    .ACTIVE_LOW(1), .LONGPRESS_CYCLES(LP)
  ) dut (
    .clk(clk), .reset_n(reset_n), .buttons(buttons), .state(state),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .evt_count(evt_count), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pop n events with ready held high, comparing each against the scoreboard head.
  task automatic consume(int n, string tag);
    int guard = 0;
    logic [3:0] e;
    evt_ready = 1'b1;
    while (!evt_valid && guard < 50) begin
      step();
      guard++;
    end
    for (int i = 0; i < n; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
      chk({tag, "_valid"}, evt_valid, 1);
      chk({tag, "_data"}, evt_data, e);
      step();
    end
    evt_ready = 1'b0;
  endtask

  task automatic press_release(int idx);
    buttons[idx] = 1'b0;
    step(10);
    buttons[idx] = 1'b1;
    step(10);
  endtask

  initial begin
    reset_n = 1'b0; buttons = 4'b1111; evt_ready = 1'b0; overflow_clr = 1'b0;
    step(3);
    chk("rst_state", state, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_count", evt_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_data", evt_data, 0);
    reset_n = 1'b1;
    step();

    // Debounce latency and press/release queueing.
    buttons[2] = 1'b0;
    step(5);
    chk("lat_state_pre", state, 4'b0000);
    step();
    chk("lat_state", state, 4'b0100);
    chk("lat_valid_pre", evt_valid, 0);
    exp_q.push_back({2'b01, 2'd2});
    step();
    chk("lat_valid", evt_valid, 1);
    chk("lat_count1", evt_count, 1);
    buttons[2] = 1'b1;
    exp_q.push_back({2'b10, 2'd2});
    step(8);
    chk("rel_state", state, 0);
    chk("rel_count", evt_count, 2);
    consume(2, "pr2");
    chk("pr2_empty", evt_count, 0);

    // Short glitch must be filtered.
    buttons[0] = 1'b0;
    step(3);
    buttons[0] = 1'b1;
    step(10);
    chk("glitch_state", state, 0);
    chk("glitch_count", evt_count, 0);
    chk("glitch_valid", evt_valid, 0);

    // Simultaneous presses come out in index order on consecutive cycles.
    buttons = 4'b0100;
    exp_q.push_back({2'b01, 2'd0});
    exp_q.push_back({2'b01, 2'd1});
    exp_q.push_back({2'b01, 2'd3});
    consume(3, "multi_press");
    chk("multi_empty", evt_count, 0);
    chk("multi_state", state, 4'b1011);
    buttons = 4'b1111;
    exp_q.push_back({2'b10, 2'd0});
    exp_q.push_back({2'b10, 2'd1});
    exp_q.push_back({2'b10, 2'd3});
    consume(3, "multi_rel");
    chk("multi_rel_empty", evt_count, 0);

    // Overflow: six events into a four-deep queue.
    exp_q.push_back({2'b01, 2'd0});
    exp_q.push_back({2'b10, 2'd0});
    exp_q.push_back({2'b01, 2'd1});
    exp_q.push_back({2'b10, 2'd1});
    press_release(0);
    press_release(1);
    chk("full_count", evt_count, 4);
    chk("full_ovf_pre", overflow, 0);
    press_release(2);
    chk("ovf_count", evt_count, 4);
    chk("ovf_set", overflow, 1);
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    chk("ovf_clr", overflow, 0);
    consume(4, "ovf_drain");
    chk("ovf_empty", evt_count, 0);
    chk("ovf_empty_data", evt_data, 0);

    // Long hold on button 1.
    exp_q.push_back({2'b01, 2'd1});
`ifdef BUTTON_LONGPRESS_EN
    exp_q.push_back({2'b11, 2'd1});
`endif
    exp_q.push_back({2'b10, 2'd1});
    buttons[1] = 1'b0;
    step(40);
    buttons[1] = 1'b1;
    step(10);
`ifdef BUTTON_LONGPRESS_EN
    chk("long_count", evt_count, 3);
    consume(3, "long");
`else
    chk("long_count", evt_count, 2);
    consume(2, "long");
`endif
    chk("long_empty", evt_count, 0);

    // Reset mid-operation drops queued events.
    buttons[3] = 1'b0;
    step(8);
    chk("mid_count", evt_count, 1);
    reset_n = 1'b0;
    step();
    chk("mid_rst_count", evt_count, 0);
    chk("mid_rst_state", state, 0);
    reset_n = 1'b1;
    buttons[3] = 1'b1;
    step(3);
    chk("mid_rst_quiet", evt_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
